// File: rtl/sram_nr1w_be.sv
// ============================================================================
// sram_nr1w_be
// ----------------------------------------------------------------------------
// Block SRAM with NUM_READ_PORTS synchronous read ports and one write port
// with per-byte enables. A read and a write to the same address in the same
// cycle return the byte-merged result: bytes being written come from wr_data,
// the remaining bytes come from the array. With CLEAR_ON_RESET=1 a clear FSM
// zeroes the whole array, one word per cycle, after every reset. Requests are
// ignored while it runs.
//
// Optional feature macro: SRAM_OUTPUT_REG_EN
//   defined   : an extra output register stage is added, so read latency is 2.
//   undefined : read latency is 1.
//
// Ports
//   clk         in   1                          clock, rising edge
//   reset       in   1                          synchronous, active-high
//   rd_en       in   NUM_READ_PORTS             per-port read enable
//   rd_addr     in   NUM_READ_PORTS*ADDR_WIDTH  port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data     out  NUM_READ_PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid    out  NUM_READ_PORTS             rd_data for port i is valid
//   wr_en       in   1                          write enable
//   wr_addr     in   ADDR_WIDTH                 write address
//   wr_byte_en  in   DATA_WIDTH/8               bit b gates wr_data[b*8 +: 8]
//   wr_data     in   DATA_WIDTH                 write data
//   init_busy   out  1                          clear FSM running
// ============================================================================
module sram_nr1w_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE           = 1024,
    parameter int ADDR_WIDTH     = $clog2(SIZE),
    parameter int NUM_READ_PORTS = 2,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_READ_PORTS-1:0]            rd_en,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ_PORTS-1:0]            rd_valid,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH/8-1:0]              wr_byte_en,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic                                 init_busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_READY    = 1'b0,
        ST_CLEARING = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   ready;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic                   clr_last;

    logic [DATA_WIDTH-1:0]  mem [SIZE];
    logic [DATA_WIDTH-1:0]  rd_word [NUM_READ_PORTS];

    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_READ_PORTS-1:0]            rd_valid_q;

    assign clr_last = (clr_cnt == ADDR_WIDTH'(SIZE - 1));

    // ------------------------------------------------------------------
    // Clear FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEARING : ST_READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEARING: if (clr_last) state_next = ST_READY;
            default:     state_next = state;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        init_busy = 1'b0;
        case (state)
            ST_READY:    ready     = 1'b1;
            ST_CLEARING: init_busy = 1'b1;
            default:     ready     = 1'b0;
        endcase
    end

    // Clear address counter; restarts from 0 on every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (init_busy) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Array write port
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch so it maps onto RAM macros; it is
    // zeroed only by the clear FSM. Writes are suppressed during reset so
    // reset itself never alters the contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_busy) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wr_byte_en[b]) begin
                        mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port read word with byte-merged write bypass
    // ------------------------------------------------------------------
    // NOTE: blocking assignments here build the word up in place: start
    // from the array contents, then overwrite the bytes being written.
    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            rd_word[i] = mem[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            if (wr_en && (wr_addr == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wr_byte_en[b]) begin
                        rd_word[i][b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // First read stage: data holds when a port is not enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_READ_PORTS; i++) begin
                rd_valid_q[i] <= ready && rd_en[i];
                if (ready && rd_en[i]) begin
                    rd_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_word[i];
                end
            end
        end
    end

`ifdef SRAM_OUTPUT_REG_EN
    // Output stage: loads only on a valid first-stage result, so rd_data
    // holds between reads. Bypass was already resolved in the address cycle.
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] out_data_q;
    logic [NUM_READ_PORTS-1:0]            out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            for (int i = 0; i < NUM_READ_PORTS; i++) begin
                if (rd_valid_q[i]) begin
                    out_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign rd_data  = out_data_q;
    assign rd_valid = out_valid_q;
`else
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sram_nr1w_be.sv
// ============================================================================
// tb_sram_nr1w_be
// ----------------------------------------------------------------------------
// Directed self-checking bench for sram_nr1w_be with DATA_WIDTH=32, SIZE=16,
// NUM_READ_PORTS=2, CLEAR_ON_RESET=1. Read latency follows
// SRAM_OUTPUT_REG_EN so the same bench covers both builds.
// ============================================================================
module tb_sram_nr1w_be;

    localparam int DW = 32;
    localparam int SZ = 16;
    localparam int AW = 4;
    localparam int NP = 2;
`ifdef SRAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NP-1:0]    rd_en = '0;
    logic [NP*AW-1:0] rd_addr = '0;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_valid;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW/8-1:0]  wr_byte_en = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             init_busy;

    int errors = 0;
    int checks = 0;

    sram_nr1w_be #(
        .DATA_WIDTH     (DW),
        .SIZE           (SZ),
        .ADDR_WIDTH     (AW),
        .NUM_READ_PORTS (NP),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_byte_en (wr_byte_en),
        .wr_data    (wr_data),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en      = '0;
        wr_en      = 1'b0;
        wr_byte_en = '0;
    endtask

    task automatic set_read(input int p, input logic [AW-1:0] a);
        rd_en[p]          = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] be);
        wr_en      = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        wr_byte_en = be;
    endtask

    // Commit the currently driven request and advance until its read result
    // is visible.
    task automatic wait_result();
        tick();
        idle();
        repeat (LAT - 1) tick();
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        set_write(a, d, 4'hF);
        tick();
        idle();
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    // Count cycles init_busy stays high (current sample included); bounded.
    task automatic count_busy(output int n, input logic poke);
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            if (poke) begin
                rd_en = n[0] ? 2'b11 : 2'b01;
                set_write(4'd3, 32'hFFFF_FFFF, 4'hF);
            end
            tick();
            n++;
            checks++;
            if (rd_valid !== 2'b00) begin
                errors++;
                $display("FAIL clear_valid: cycle %0d rd_valid=%b expected 00", n, rd_valid);
            end
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 00", rd_valid);
        end
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", rd_data);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 1", init_busy);
        end
    endtask

    task automatic test_clear();
        int n;
        count_busy(n, 1'b0);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL clear_cycles: got %0d expected 16", n);
        end
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: init_busy=%b expected 0", init_busy);
        end
        for (int a = 0; a < SZ; a += 2) begin
            set_read(0, AW'(a));
            set_read(1, AW'(a + 1));
            wait_result();
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (rd_valid[p] !== 1'b1 || port_data(p) !== 32'h0) begin
                    errors++;
                    $display("FAIL clear_read: addr %0d got valid=%b data=%h expected 1/00000000",
                             a + p, rd_valid[p], port_data(p));
                end
            end
        end
    endtask

    task automatic test_write_read();
        write_word(4'd3, 32'hDEAD_BEEF);
        set_read(0, 4'd3);
        wait_result();
        checks++;
        if (rd_valid !== 2'b01 || port_data(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read: got valid=%b data=%h expected 01/deadbeef",
                     rd_valid, port_data(0));
        end
        // No read issued: valid drops, data holds.
        tick();
        checks++;
        if (rd_valid !== 2'b00 || port_data(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_hold: got valid=%b data=%h expected 00/deadbeef",
                     rd_valid, port_data(0));
        end
    endtask

    task automatic test_bypass();
        write_word(4'd5, 32'h1122_3344);
        set_write(4'd5, 32'hAABB_CCDD, 4'b0101);
        set_read(0, 4'd5);
        set_read(1, 4'd5);
        wait_result();
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (rd_valid[p] !== 1'b1 || port_data(p) !== 32'h11BB_33DD) begin
                errors++;
                $display("FAIL bypass_port%0d: got valid=%b data=%h expected 1/11bb33dd",
                         p, rd_valid[p], port_data(p));
            end
        end
        set_read(1, 4'd5);
        wait_result();
        checks++;
        if (rd_valid !== 2'b10 || port_data(1) !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL bypass_stored: got valid=%b data=%h expected 10/11bb33dd",
                     rd_valid, port_data(1));
        end
    endtask

    task automatic test_independent_ports();
        write_word(4'd2, 32'h0000_0002);
        write_word(4'd9, 32'h0000_0009);
        set_read(0, 4'd2);
        set_read(1, 4'd9);
        set_write(4'd7, 32'h7777_7777, 4'hF);
        wait_result();
        checks++;
        if (rd_valid !== 2'b11 || port_data(0) !== 32'h2 || port_data(1) !== 32'h9) begin
            errors++;
            $display("FAIL indep_ports: got valid=%b p0=%h p1=%h expected 11/00000002/00000009",
                     rd_valid, port_data(0), port_data(1));
        end
        // Write with no byte enables is a no-op.
        set_write(4'd7, 32'h0, 4'h0);
        tick();
        idle();
        set_read(0, 4'd7);
        wait_result();
        checks++;
        if (rd_valid[0] !== 1'b1 || port_data(0) !== 32'h7777_7777) begin
            errors++;
            $display("FAIL addr7_after_noop: got valid=%b data=%h expected 1/77777777",
                     rd_valid[0], port_data(0));
        end
    endtask

    task automatic test_latency();
        write_word(4'd3, 32'h1234_5678);
        set_read(0, 4'd3);
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd_valid[0] !== (k == LAT - 1)) begin
                errors++;
                $display("FAIL latency_valid: sample %0d got %b expected %b",
                         k, rd_valid[0], (k == LAT - 1));
            end
            if (k == LAT - 1) begin
                checks++;
                if (port_data(0) !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL latency_data: got %h expected 12345678", port_data(0));
                end
            end
            idle();
            if (k == 0) set_write(4'd3, 32'hCAFE_F00D, 4'hF);
            tick();
        end
        idle();
        set_read(0, 4'd3);
        wait_result();
        checks++;
        if (port_data(0) !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL latency_newdata: got %h expected cafef00d", port_data(0));
        end
    endtask

    task automatic test_mid_clear_reset();
        int n;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_en = 2'b11;
            tick();
            checks++;
            if (init_busy !== 1'b1 || rd_valid !== 2'b00) begin
                errors++;
                $display("FAIL partial_clear: cycle %0d busy=%b valid=%b expected 1/00",
                         k, init_busy, rd_valid);
            end
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n, 1'b1);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL restart_cycles: got %0d expected 16", n);
        end
        set_read(0, 4'd3);
        set_read(1, 4'd9);
        wait_result();
        checks++;
        if (rd_valid !== 2'b11 || port_data(0) !== 32'h0 || port_data(1) !== 32'h0) begin
            errors++;
            $display("FAIL restart_read: got valid=%b p0=%h p1=%h expected 11/0/0",
                     rd_valid, port_data(0), port_data(1));
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_bypass();
        test_independent_ports();
        test_latency();
        test_mid_clear_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
